asu_serial: RTL and testbench
=============================

Name: asu_serial

Overview:
- Sequential, handshaked responder implementing the ASU add/shift function.
- Accepts one operand pair (x, y, mode) per transaction, computes the result over multiple cycles and returns {carry, out} on a valid/ready output port.
- Add is bit-serial; shift moves one position per cycle.
- Sits behind a pattern driver/checker in the HW1 datapath and produces results bit-identical to the combinational ASU.

Parameters:
- W, 8, operand and result width.
- SHW, 3, shift-amount width; must equal log2(W).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operand pair present.
- in_ready, output, 1, block can accept operands.
- x, input, W, operand A.
- y, input, W, operand B.
- mode, input, 1, 1 = add, 0 = shift.
- out_valid, output, 1, result present.
- out_ready, input, 1, consumer accepts result.
- out, output, W, result.
- carry, output, 1, add carry-out; 0 in shift mode.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, out = 0, carry = 0. All internal registers are cleared.
- Reset asserted mid-operation aborts the operation immediately. No result is produced, and the first cycle after release is IDLE.
- Function, mode 1: {carry, out} = x + y, unsigned, W+1 bits.
- Function, mode 0: out = (x << y[SHW-1:0]) truncated to W bits; carry = 0. y[W-1:SHW] is ignored.
- Accept rule: a transaction is accepted on a rising edge with in_valid & in_ready. x, y and mode are latched at that edge; later input changes have no effect.
- in_ready is 1 only in IDLE. No input bubble buffering.
- State IDLE:
  - On accept with mode = 1: load A = x, B = y, c = 0, bit counter k = 0, go to ADD.
  - On accept with mode = 0: load R = x, shift counter s = y[SHW-1:0]. If s == 0, go to DONE; otherwise go to SHIFT.
- State ADD, one bit per cycle:
  - sum_k = A[k] ^ B[k] ^ c.
  - c = majority(A[k], B[k], c).
  - R[k] = sum_k.
  - k increments each cycle; after k = W-1, go to DONE with carry = final c.
  - Exactly W cycles are spent in ADD.
- State SHIFT, one position per cycle:
  - R = R << 1 and s = s - 1 each cycle.
  - When s reaches 0, go to DONE.
  - Exactly y[SHW-1:0] cycles are spent in SHIFT.
- State DONE:
  - out_valid = 1; out = R and carry are held stable until the handshake.
  - When out_valid & out_ready is seen at an edge, go to IDLE. in_ready rises on the next cycle; no same-cycle turnaround.
- Latency from accept edge to out_valid high:
  - add: W+1 cycles.
  - shift: s+1 cycles.
  - shift with s = 0: 1 cycle.
- Backpressure: out_ready low holds DONE indefinitely with out and carry unchanged.
- out and carry are registered; no combinational path from any input to any output.
- Wrap-around:
  - 0xFF + 0x01 gives out = 0x00, carry = 1.
  - A shift by 7 keeps only the low bit of x, moved to bit 7.

Decomposition:
- Shared package asu_pkg holds:
  - the state encoding (IDLE = 2'd0, ADD = 2'd1, SHIFT = 2'd2, DONE = 2'd3);
  - the mode constants MODE_ADD = 1'b1 and MODE_SHIFT = 1'b0;
  - W = 8 and SHW = 3.
- One natural sub-module, asu_fa_bit: a single-bit full adder (a, b, cin -> s, cout) instantiated once in the ADD datapath.
- The FSM, counters and shift register stay in asu_serial.

Test Plan:
- Reset mid-add: start add x = 0x3C, y = 0x0F, assert rst_n low after 4 cycles -> out_valid = 0, out = 0, in_ready = 1 on release; no stale result ever appears.
- Add with carry: mode = 1, x = 0xFF, y = 0x01, out_ready = 1 -> out_valid exactly 9 cycles after accept, out = 0x00, carry = 1.
- Plain add: mode = 1, x = 0x5A, y = 0x33 -> out = 0x8D, carry = 0.
- Shift boundaries, each with carry = 0:
  - mode = 0, x = 0x81, y = 0x07 -> out = 0x80 after 8 cycles.
  - y = 0x00 -> out = 0x81 after 1 cycle.
  - y = 0xF9 -> upper bits ignored, shift by 1, out = 0x02.
- Backpressure and input stability: hold out_ready = 0 for 20 cycles in DONE, toggle x, y and mode meanwhile -> out and carry stay stable, in_ready stays 0; releasing out_ready returns to IDLE with in_ready = 1 one cycle later.
- Back-to-back regression: stream the 11 HW1 Msel/Min patterns with in_valid held high -> each {carry, out} matches Mout_golden in order, with no dropped or duplicated transactions.

Source files
------------

// File: rtl/asu_pkg.sv
// rtl/asu_pkg.sv - shared constants and FSM state encoding for the serial ASU
package asu_pkg;

    localparam int W   = 8;
    localparam int SHW = 3;

    localparam logic MODE_ADD   = 1'b1;
    localparam logic MODE_SHIFT = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADD   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } asu_state_e;

endpackage

// File: rtl/asu_serial_if.sv
// rtl/asu_serial_if.sv - operand/result handshake bundle for the serial ASU
interface asu_serial_if #(
    parameter int W = asu_pkg::W
);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         carry;

    modport master (
        output in_valid, x, y, mode, out_ready,
        input  in_ready, out_valid, out, carry
    );

    modport slave (
        input  in_valid, x, y, mode, out_ready,
        output in_ready, out_valid, out, carry
    );

endinterface

// File: rtl/asu_fa_bit.sv
// rtl/asu_fa_bit.sv - single-bit full adder used by the bit-serial add path
module asu_fa_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    // sum and majority carry of the three input bits
    always_comb begin
        s_o    = a_i ^ b_i ^ cin_i;
        cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
    end

endmodule

// File: rtl/asu_serial.sv
// rtl/asu_serial.sv - handshaked multi-cycle ASU: bit-serial add, one-step-per-cycle shift
module asu_serial #(
    parameter int W   = asu_pkg::W,
    parameter int SHW = asu_pkg::SHW
) (
    input  logic         clk,
    input  logic         rst_n,
    asu_serial_if.slave  bus
);

    import asu_pkg::*;

    asu_state_e     state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   r_q, r_d;
    logic           c_q, c_d;
    logic           carry_q, carry_d;
    logic [SHW-1:0] k_q, k_d;
    logic [SHW-1:0] s_q, s_d;
    logic           fa_s;
    logic           fa_cout;

    asu_fa_bit u_fa (
        .a_i    (a_q[k_q]),
        .b_i    (b_q[k_q]),
        .cin_i  (c_q),
        .s_o    (fa_s),
        .cout_o (fa_cout)
    );

    // state and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            k_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            s_q     <= s_d;
        end
    end

    // next-state and datapath update for accept, add, shift and result hold
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        c_d     = c_q;
        carry_d = carry_q;
        k_d     = k_q;
        s_d     = s_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    carry_d = 1'b0;
                    if (bus.mode == MODE_ADD) begin
                        a_d     = bus.x;
                        b_d     = bus.y;
                        r_d     = '0;
                        c_d     = 1'b0;
                        k_d     = '0;
                        state_d = ST_ADD;
                    end else begin
                        r_d     = bus.x;
                        s_d     = bus.y[SHW-1:0];
                        state_d = (bus.y[SHW-1:0] == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
            end
            ST_ADD: begin
                r_d[k_q] = fa_s;
                c_d      = fa_cout;
                k_d      = k_q + 1'b1;
                if (k_q == SHW'(W - 1)) begin
                    carry_d = fa_cout;
                    state_d = ST_DONE;
                end
            end
            ST_SHIFT: begin
                r_d = r_q << 1;
                s_d = s_q - 1'b1;
                if (s_q == SHW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out       = r_q;
    assign bus.carry     = carry_q;

endmodule

// File: tb/tb_asu_serial.sv
// tb/tb_asu_serial.sv - randomized self-checking bench for the serial ASU
module tb_asu_serial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    asu_serial_if bus ();

    asu_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {carry, out} from plain arithmetic on the operands
    function automatic logic [8:0] ref_model(input logic [7:0] a, input logic [7:0] b, input logic m);
        int r;
        if (m) r = int'(a) + int'(b);
        else   r = (int'(a) * (1 << (int'(b) % 8))) % 256;
        return r[8:0];
    endfunction

    function automatic int ref_latency(input logic [7:0] b, input logic m);
        return m ? 9 : (int'(b) % 8) + 1;
    endfunction

    task automatic scramble();
        bus.x    = 8'($urandom);
        bus.y    = 8'($urandom);
        bus.mode = 1'($urandom);
    endtask

    // single transaction: latency, result, backpressure stability, return to idle
    task automatic run_one(input string tag, input logic [7:0] xv, input logic [7:0] yv,
                           input logic mv, input int stall);
        logic [8:0] exp;
        int         lat;
        int         guard;
        exp   = ref_model(xv, yv, mv);
        guard = 0;
        @(negedge clk);
        bus.x = xv; bus.y = yv; bus.mode = mv;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_ready"}, bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        scramble();
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, ref_latency(yv, mv));
        check({tag, "_result"}, {bus.carry, bus.out}, exp);
        check({tag, "_in_ready_busy"}, bus.in_ready, 0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            scramble();
            bus.in_valid = 1'($urandom);
            check({tag, "_hold"}, {bus.in_ready, bus.out_valid, bus.carry, bus.out}, {2'b01, exp});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_release"}, {bus.in_ready, bus.out_valid}, 2'b10);
    endtask

    logic [7:0] px[$];
    logic [7:0] py[$];
    logic       pm[$];

    // stream the queued patterns with in_valid held high; scoreboard checks order and count
    task automatic stream(input string tag, input bit rand_ready);
        logic [8:0] expq[$];
        int n, sent, got, cyc;
        bit acc, fin;
        n = px.size(); sent = 0; got = 0; cyc = 0;
        @(posedge clk); #1;
        bus.x = px[0]; bus.y = py[0]; bus.mode = pm[0];
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        while (got < n && cyc < n * 30 + 50) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            fin = bus.out_valid && bus.out_ready;
            if (fin) begin
                if (expq.size() == 0) check({tag, "_extra"}, 1, 0);
                else check({tag, "_result"}, {bus.carry, bus.out}, expq.pop_front());
                got++;
            end
            if (acc) expq.push_back(ref_model(px[sent], py[sent], pm[sent]));
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                if (sent < n) begin
                    bus.x = px[sent]; bus.y = py[sent]; bus.mode = pm[sent];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (rand_ready) bus.out_ready = 1'($urandom);
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        check({tag, "_count"}, got, n);
        check({tag, "_sent"}, sent, n);
        px.delete(); py.delete(); pm.delete();
    endtask

    initial begin
        bit stale;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.x = '0; bus.y = '0; bus.mode = 1'b0;

        #1;
        check("reset_outputs", {bus.in_ready, bus.out_valid, bus.carry, bus.out}, {2'b10, 9'h000});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {bus.in_ready, bus.out_valid, bus.carry, bus.out}, {2'b10, 9'h000});

        // reset in the middle of an add
        @(negedge clk);
        bus.x = 8'h3C; bus.y = 8'h0F; bus.mode = 1'b1;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_outputs", {bus.in_ready, bus.out_valid, bus.carry, bus.out}, {2'b10, 9'h000});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_release", {bus.in_ready, bus.out_valid, bus.carry, bus.out}, {2'b10, 9'h000});
        stale = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.out_valid) stale = 1'b1;
        end
        check("midreset_no_stale", stale, 0);
        bus.out_ready = 1'b0;

        // directed boundaries
        run_one("add_carry", 8'hFF, 8'h01, 1'b1, 0);
        run_one("add_plain", 8'h5A, 8'h33, 1'b1, 0);
        run_one("shift7",    8'h81, 8'h07, 1'b0, 0);
        run_one("shift0",    8'h81, 8'h00, 1'b0, 0);
        run_one("shift_hi",  8'h81, 8'hF9, 1'b0, 0);
        run_one("backpress", 8'hC7, 8'h9E, 1'b1, 20);
        run_one("bp_shift",  8'h35, 8'h02, 1'b0, 20);

        // back-to-back pattern table
        px = '{8'hFF, 8'h5A, 8'h81, 8'h81, 8'h81, 8'h00, 8'h80, 8'hFF, 8'h3C, 8'h01, 8'h7F};
        py = '{8'h01, 8'h33, 8'h07, 8'h00, 8'hF9, 8'h00, 8'h80, 8'h03, 8'h0F, 8'h05, 8'h7F};
        pm = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
        stream("hw1", 1'b0);

        // random operands with random consumer backpressure
        for (int i = 0; i < 60; i++) begin
            px.push_back(8'($urandom));
            py.push_back(8'($urandom));
            pm.push_back(1'($urandom));
        end
        stream("rand", 1'b1);

        for (int i = 0; i < 6; i++)
            run_one("rand_one", 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 5)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
